// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one-word fetches to a fixed one-cycle-latency
// instruction memory, buffers the responses in a 2-entry in-order FIFO and
// offers them to decode with a valid/ready handshake. Fetching stops at
// HALT_WORD. The unit then drains the buffered words and parks in HALTED.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [15:0] insn;
    logic [15:0] pc;
  } entry_t;

  state_t      state;
  entry_t      fifo [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        pending;
  logic [15:0] pending_pc;
  logic [15:0] fetch_pc;

  logic        deq;
  logic        resp_ok;
  logic        is_halt;
  logic        enq;
  logic        halt_hit;
  logic [2:0]  occupancy;
  logic [1:0]  count_next;

  // A response is meaningful only when it answers a request issued last cycle.
  assign resp_ok  = imem_rvalid && pending;
  assign is_halt  = (imem_rdata == HALT_WORD);
  assign enq      = resp_ok && !is_halt && (state == FETCH);
  assign halt_hit = resp_ok && is_halt && (state == FETCH);
  assign deq      = (count != 2'd0) && ir_ready;

  // Slots already promised: buffered words plus the response still in flight.
  // deq implies count >= 1, so this never underflows.
  assign occupancy  = {1'b0, count} + {2'b00, pending} - {2'b00, deq};
  assign count_next = count + {1'b0, enq} - {1'b0, deq};

  // reset_n gates the request so nothing is issued while reset is held.
  assign imem_req  = reset_n && (state == FETCH) && (occupancy < 3'd2);
  assign imem_addr = fetch_pc;

  // No bypass: a word becomes visible the cycle after it is written.
  assign ir_valid = (count != 2'd0);
  assign ir       = fifo[head].insn;
  assign ir_pc    = fifo[head].pc;
  assign halted   = (state == HALTED);

  // Fetch pointer, outstanding-request tracking, FIFO pointers and state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of code order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= 16'h0000;
      count      <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      state      <= FETCH;
    end else begin
      pending <= imem_req;
      if (imem_req) begin
        fetch_pc   <= fetch_pc + 16'd2;
        pending_pc <= fetch_pc;
      end
      count <= count_next;
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      case (state)
        // Skip DRAIN when nothing is left to deliver.
        FETCH:   if (halt_hit) state <= (count_next == 2'd0) ? HALTED : DRAIN;
        DRAIN:   if (count_next == 2'd0) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  // Instruction buffer storage, written at the tail on every enqueue.
  // NOTE: the storage is reset because ir/ir_pc must read zero during reset;
  // larger buffers would normally be left unreset and qualified by valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else if (enq) begin
      fifo[tail] <= '{insn: imem_rdata, pc: pending_pc};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. A behavioural instruction
// memory answers each request one cycle later. Every non-halt answer is pushed
// to a scoreboard and popped when decode accepts a word.
module tb_instruction_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        ir_ready = 1'b0;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        halted;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ir_valid;
  logic [15:0] w_ir;
  logic [15:0] w_ir_pc;
  logic        w_halted;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .halted      (halted)
  );

  // Second instance only watches the address wrap from the top of memory.
  instruction_fetch_unit #(.RESET_PC(16'hFFFC)) u_wrap (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_valid    (w_ir_valid),
    .ir_ready    (ir_ready),
    .ir          (w_ir),
    .ir_pc       (w_ir_pc),
    .halted      (w_halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] insn;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] ready_pat;
    logic [15:0] halt_addr;
    int          exp_delivered;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  bit          halt_en;
  logic [15:0] halt_addr;
  bit          halt_seen;
  int          delivered;
  int          nreq;
  logic [15:0] last_req_addr;
  bit          prev_stall;
  logic [15:0] prev_ir;
  logic [15:0] prev_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (halt_en && a == halt_addr) return HALT;
    return a ^ 16'h5A00;
  endfunction

  // One clock cycle: sample settled outputs, cross the edge, answer the
  // request seen this cycle, then set ir_ready for the next cycle.
  task automatic step(input bit next_ready);
    logic        s_req;
    logic [15:0] s_addr;
    logic [15:0] w;
    exp_t        e;
    if (prev_stall) begin
      check("hold_valid", {31'b0, ir_valid}, 32'd1);
      check("hold_ir", {ir, ir_pc}, {prev_ir, prev_pc});
    end
    prev_stall = ir_valid && !ir_ready;
    prev_ir    = ir;
    prev_pc    = ir_pc;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (s_req) begin
      nreq++;
      last_req_addr = s_addr;
    end
    if (ir_valid && ir_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ir=%h pc=%h expected no delivery", ir, ir_pc);
      end else begin
        e = sb.pop_front();
        check("sb_ir", {16'h0, ir}, {16'h0, e.insn});
        check("sb_pc", {16'h0, ir_pc}, {16'h0, e.pc});
      end
      delivered++;
    end
    @(posedge clock);
    #1;
    imem_rvalid = s_req;
    if (s_req) begin
      w = word_at(s_addr);
      imem_rdata = w;
      if (!halt_seen) begin
        if (w == HALT) halt_seen = 1'b1;
        else sb.push_back('{insn: w, pc: s_addr});
      end
    end
    ir_ready = next_ready;
    #1;
  endtask

  // Asynchronous reset in mid-cycle, then release with a stale response on
  // the bus that must be ignored.
  task automatic reset_dut(input bit rdy);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_ir", {ir, ir_pc}, 32'd0);
    imem_rvalid = 1'b0;
    sb.delete();
    halt_seen     = 1'b0;
    delivered     = 0;
    nreq          = 0;
    last_req_addr = 16'h0000;
    prev_stall    = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'h1234;
    ir_ready    = rdy;
    reset_n     = 1'b1;
    #1;
  endtask

  vec_t        vecs [6];
  logic [15:0] wrap_exp [4];

  initial begin
    vecs[0] = '{ready_pat: 16'hFFFF, halt_addr: 16'd6,  exp_delivered: 3};
    vecs[1] = '{ready_pat: 16'hAAAA, halt_addr: 16'd10, exp_delivered: 5};
    vecs[2] = '{ready_pat: 16'hCCCC, halt_addr: 16'd8,  exp_delivered: 4};
    vecs[3] = '{ready_pat: 16'hFFFF, halt_addr: 16'd0,  exp_delivered: 0};
    vecs[4] = '{ready_pat: 16'h1111, halt_addr: 16'd12, exp_delivered: 6};
    vecs[5] = '{ready_pat: 16'h0101, halt_addr: 16'd4,  exp_delivered: 2};
    wrap_exp[0] = 16'hFFFC;
    wrap_exp[1] = 16'hFFFE;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0002;

    // Streaming: first request at RESET_PC, two-cycle latency, one per cycle.
    halt_en = 1'b0;
    halt_addr = 16'h0000;
    reset_dut(1'b1);
    check("first_req", {imem_req, 15'b0, imem_addr}, {1'b1, 15'b0, 16'h0000});
    step(1'b1);
    check("lat_c1_valid", {31'b0, ir_valid}, 32'd0);
    check("lat_c1_addr", {16'h0, imem_addr}, 32'd2);
    step(1'b1);
    check("lat_c2_valid", {31'b0, ir_valid}, 32'd1);
    check("lat_c2_ir", {ir, ir_pc}, {word_at(16'h0000), 16'h0000});
    for (int i = 0; i < 5; i++) step(1'b1);
    check("stream_delivered", delivered, 32'd5);

    // Backpressure: two requests then stall, W0 held, then W0..W2 in order.
    reset_dut(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0);
    check("bp_held_ir", {ir_valid, 15'b0, ir}, {1'b1, 15'b0, word_at(16'h0000)});
    check("bp_req_low", {31'b0, imem_req}, 32'd0);
    step(1'b1);
    check("bp_nreq", nreq, 32'd2);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("bp_delivered", delivered, 32'd3);

    // Halt at address 6 with decode always ready.
    halt_en = 1'b1;
    halt_addr = 16'd6;
    reset_dut(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("halt_c4_halted", {31'b0, halted}, 32'd0);
    step(1'b1);
    check("halt_c5_halted", {31'b0, halted}, 32'd1);
    check("halt_c5_delivered", delivered, 32'd3);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("halt_last_req", {16'h0, last_req_addr}, 32'd8);
    check("halt_req_low", {31'b0, imem_req}, 32'd0);
    check("halt_sb_empty", sb.size(), 32'd0);

    // Halt word returns while decode stalls: DRAIN holds until W0 is taken.
    halt_addr = 16'd2;
    reset_dut(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0);
    check("drain_c3", {halted, imem_req, ir_valid, 13'b0, ir}, {3'b001, 13'b0, word_at(16'h0000)});
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("drain_c6_halted", {31'b0, halted}, 32'd0);
    step(1'b1);
    check("drain_c7_halted", {ir_valid, halted}, 2'b01);
    check("drain_delivered", delivered, 32'd1);

    // Address wrap from the top of memory.
    halt_en = 1'b0;
    reset_dut(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("wrap_addr", {w_req, 15'b0, w_addr}, {1'b1, 15'b0, wrap_exp[i]});
      step(1'b1);
    end

    // Reset mid-stream with a word buffered and a response in flight.
    reset_dut(1'b0);
    step(1'b0);
    step(1'b0);
    check("mid_pre_valid", {31'b0, ir_valid}, 32'd1);
    reset_dut(1'b1);
    check("mid_first_req", {imem_req, 15'b0, imem_addr}, {1'b1, 15'b0, 16'h0000});
    step(1'b1);
    check("mid_stale_dropped", {31'b0, ir_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("mid_delivered", delivered, 32'd3);

    // Table-driven halt runs under assorted ready patterns.
    halt_en = 1'b1;
    foreach (vecs[k]) begin
      halt_addr = vecs[k].halt_addr;
      reset_dut(vecs[k].ready_pat[0]);
      for (int c = 0; c < 60; c++) step(vecs[k].ready_pat[(c + 1) % 16]);
      check($sformatf("vec%0d_delivered", k), delivered, vecs[k].exp_delivered);
      check($sformatf("vec%0d_final", k), {halted, ir_valid, imem_req}, 3'b100);
      check($sformatf("vec%0d_sb_empty", k), sb.size(), 32'd0);
      check($sformatf("vec%0d_no_req_past_halt", k),
            {31'b0, (last_req_addr <= vecs[k].halt_addr + 16'd2)}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
